mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory-stage consumer of the EX/MEM pipeline register outputs (M_* signals).
//  Turns M-stage load/store control into data-memory bus transactions: byte lanes, LWL/LWR/SWL/SWR merge, LL/SC, alignment exceptions.
//  Generates the M-stage memory stall while a transaction is outstanding; returns load data toward MEM/WB.
// PARAMETERS
//  ADDR_WIDTH  30  word-address width driven on DataMem_Address (byte addr bits [ADDR_WIDTH+1:2])
// PORTS
//  clock            in   1   single clock
//  reset            in   1   asynchronous, active-high
//  M_MemRead/M_MemWrite in 1 each   access request
//  M_MemByte/M_MemHalf  in 1 each   size (neither = word)
//  M_MemSignExtend  in   1   sign-extend byte/half loads
//  M_Left/M_Right   in   1 each   LWL/SWL, LWR/SWR
//  M_ReverseEndian  in   1   little-endian lane mapping
//  M_LLSC           in   1   LL (with read) / SC (with write)
//  M_ALU_Result     in   32  byte address
//  M_ReadData2      in   32  store data / old rt for LWL/LWR
//  M_Flush          in   1   kill current M-stage access
//  M_Stall          in   1   external M-stage stall (hazard unit)
//  M_Eret           in   1   ERET in M; clears LL bit
//  DataMem_In       in   32  read data
//  DataMem_Ready    in   1   transaction complete
//  DataMem_Address  out  ADDR_WIDTH
//  DataMem_Read     out  1
//  DataMem_Write    out  4   byte enables, [3]=bits 31:24
//  DataMem_Out      out  32
//  M_MemStall       out  1   stall request to hazard unit
//  M_ReadData       out  32  load result / SC status
//  M_Exc_AdEL/M_Exc_AdES out 1 each  load/store address error
// BEHAVIOUR
//  Reset: FSM=IDLE, LLbit=0, LLaddr=0, all outputs 0.
//  Alignment: word needs addr[1:0]=0, half needs addr[0]=0; Left/Right exempt. Misaligned -> AdEL(read)/AdES(write) same cycle, no request, M_MemStall=0.
//  Valid = (Read|Write) & aligned & ~M_Flush & ~SC-fail.
//  Lanes: eff offset = addr[1:0] ^ {2{M_ReverseEndian}}; big-endian offset 0 = bits 31:24.
//  Byte store: data replicated x4, one-hot enable (off0=1000). Half: off0=1100, off2=0011.
//  LWL off0..3: mem, {mem[23:0],rt[7:0]}, {mem[15:0],rt[15:0]}, {mem[7:0],rt[23:0]}.
//  LWR off0..3: {rt[31:8],mem[31:24]}, {rt[31:16],mem[31:16]}, {rt[31:24],mem[31:8]}, mem.
//  SWL off0..3: en 1111/0111/0011/0001, data rt>>0/8/16/24. SWR: en 1000/1100/1110/1111, data rt<<24/16/8/0.
//  FSM IDLE: request driven combinationally when Valid. Ready same cycle -> 0 stall cycles; latch data; go DONE if M_Stall else stay IDLE. No Ready -> ACCESS, M_MemStall=1.
//  ACCESS: request held stable; M_MemStall=1 until Ready; on Ready latch data, -> DONE if M_Stall else IDLE.
//  DONE: no request (no re-issue of held instruction), M_MemStall=0, M_ReadData from latch; -> IDLE when M_Stall=0.
//  M_Flush in ACCESS: transaction still completes (bus not aborted); data discarded; -> IDLE.
//  LL: completed load sets LLbit=1, LLaddr=addr[31:2]. SC: LLbit & addr match -> write, M_ReadData=1; else no bus access, M_ReadData=0, no stall. Any SC or M_Eret clears LLbit (Eret wins same cycle).
//  Reset mid-ACCESS: abandon, IDLE, request deasserted.
// STRUCTURE
//  Shared package/header: FSM state encodings, size codes, byte-enable constants.
//  Sub-module mem_lane_align: combinational store steering + load extract/merge/extend; FSM and LL logic stay in top.
// TESTING
//  LB addr 0x...01, mem 0x11_82_33_44, SignExt=1, Ready same cycle -> ReadData 0xFFFFFF82, MemStall never 1.
//  SH addr 0x...02 rt=0x0000BEEF, Ready after 3 cycles -> Write=0011, Out=0xBEEFBEEF, MemStall=1 for 3 cycles.
//  LW addr 0x...02 -> AdEL=1, DataMem_Read=0; SW addr 0x...01 -> AdES=1, Write=0000.
//  LWL addr off1, mem 0xAABBCCDD, rt 0x11223344 -> 0xBBCCDD44; SWR off2 -> en 1110, data 0x22334400.
//  LL 0x100, SC 0x100 -> write, ReadData=1; second SC -> no write, ReadData=0; LL, Eret, SC -> fail.
//  M_Stall held 4 cycles after Ready -> exactly one bus request; M_Flush during ACCESS -> Ready honoured, then IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types and constants for the M-stage memory access controller
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } ctrlState_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } memSize_t;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_HI_BYTE = 4'b1000;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;

    typedef struct packed {
        logic        read;
        logic        write;
        memSize_t    size;
        logic        signExt;
        logic        left;
        logic        right;
        logic        reverseEndian;
        logic        llsc;
        logic [31:0] addr;
        logic [31:0] rt;
    } memReq_t;

    function automatic memSize_t sizeCode(input logic isByte, input logic isHalf);
        if (isByte) begin
            return SIZE_BYTE;
        end else if (isHalf) begin
            return SIZE_HALF;
        end
        return SIZE_WORD;
    endfunction

    // Left/Right partial-word accesses are never misaligned.
    function automatic logic isAligned(input memSize_t size, input logic [1:0] low, input logic partial);
        if (partial) begin
            return 1'b1;
        end
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~low[0];
            default:   return low == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane steering and load extract/merge/extend for one access
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  memSize_t    size,
    input  logic [1:0]  offset,
    input  logic        signExt,
    input  logic        left,
    input  logic        right,
    input  logic [31:0] storeData,
    input  logic [31:0] memData,
    output logic [3:0]  byteEn,
    output logic [31:0] storeOut,
    output logic [31:0] loadOut
);

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;

    always_comb begin
        byteEn   = BE_ALL;
        storeOut = storeData;
        loadOut  = memData;
        case (offset)
            2'd0:    laneByte = memData[31:24];
            2'd1:    laneByte = memData[23:16];
            2'd2:    laneByte = memData[15:8];
            default: laneByte = memData[7:0];
        endcase
        laneHalf = offset[1] ? memData[15:0] : memData[31:16];

        if (left) begin
            byteEn   = BE_ALL >> offset;
            storeOut = storeData >> {offset, 3'b000};
            case (offset)
                2'd0:    loadOut = memData;
                2'd1:    loadOut = {memData[23:0], storeData[7:0]};
                2'd2:    loadOut = {memData[15:0], storeData[15:0]};
                default: loadOut = {memData[7:0], storeData[23:0]};
            endcase
        end else if (right) begin
            byteEn   = BE_ALL << ~offset;
            storeOut = storeData << {~offset, 3'b000};
            case (offset)
                2'd0:    loadOut = {storeData[31:8], memData[31:24]};
                2'd1:    loadOut = {storeData[31:16], memData[31:16]};
                2'd2:    loadOut = {storeData[31:24], memData[31:8]};
                default: loadOut = memData;
            endcase
        end else begin
            case (size)
                SIZE_BYTE: begin
                    byteEn   = BE_HI_BYTE >> offset;
                    storeOut = {4{storeData[7:0]}};
                    loadOut  = {{24{signExt & laneByte[7]}}, laneByte};
                end
                SIZE_HALF: begin
                    byteEn   = offset[1] ? BE_LO_HALF : BE_HI_HALF;
                    storeOut = {2{storeData[15:0]}};
                    loadOut  = {{16{signExt & laneHalf[15]}}, laneHalf};
                end
                default: begin
                    byteEn   = BE_ALL;
                    storeOut = storeData;
                    loadOut  = memData;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - M-stage data memory bus controller with LL/SC and alignment checks
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  M_MemRead,
    input  logic                  M_MemWrite,
    input  logic                  M_MemByte,
    input  logic                  M_MemHalf,
    input  logic                  M_MemSignExtend,
    input  logic                  M_Left,
    input  logic                  M_Right,
    input  logic                  M_ReverseEndian,
    input  logic                  M_LLSC,
    input  logic [31:0]           M_ALU_Result,
    input  logic [31:0]           M_ReadData2,
    input  logic                  M_Flush,
    input  logic                  M_Stall,
    input  logic                  M_Eret,
    input  logic [31:0]           DataMem_In,
    input  logic                  DataMem_Ready,
    output logic [ADDR_WIDTH-1:0] DataMem_Address,
    output logic                  DataMem_Read,
    output logic [3:0]            DataMem_Write,
    output logic [31:0]           DataMem_Out,
    output logic                  M_MemStall,
    output logic [31:0]           M_ReadData,
    output logic                  M_Exc_AdEL,
    output logic                  M_Exc_AdES
);

    ctrlState_t  state;
    memReq_t     liveReq;
    memReq_t     heldReq;
    memReq_t     curReq;
    logic        llBit;
    logic [29:0] llAddr;
    logic [31:0] dataLatch;
    logic        flushed;

    logic        aligned;
    logic        isSc;
    logic        scFail;
    logic        valid;
    logic        issue;
    logic        completing;
    logic        discard;
    logic [1:0]  effOffset;
    logic [3:0]  laneEn;
    logic [31:0] laneStore;
    logic [31:0] laneLoad;
    logic [31:0] result;

    assign liveReq = '{
        read:          M_MemRead,
        write:         M_MemWrite,
        size:          sizeCode(M_MemByte, M_MemHalf),
        signExt:       M_MemSignExtend,
        left:          M_Left,
        right:         M_Right,
        reverseEndian: M_ReverseEndian,
        llsc:          M_LLSC,
        addr:          M_ALU_Result,
        rt:            M_ReadData2
    };

    // The bus sees a frozen copy while waiting, so a flush or pipeline change cannot disturb it.
    assign curReq = (state == ST_ACCESS) ? heldReq : liveReq;

    assign aligned = isAligned(liveReq.size, M_ALU_Result[1:0], M_Left | M_Right);
    assign isSc    = M_LLSC & M_MemWrite;
    assign scFail  = isSc & ~(llBit & (llAddr == M_ALU_Result[31:2]));
    assign valid   = ~reset & (M_MemRead | M_MemWrite) & aligned & ~M_Flush & ~scFail;

    assign issue      = ((state == ST_IDLE) & valid) | ((state == ST_ACCESS) & ~reset);
    assign completing = issue & DataMem_Ready;
    assign discard    = (state == ST_ACCESS) & (flushed | M_Flush);
    assign effOffset  = curReq.addr[1:0] ^ {2{curReq.reverseEndian}};

    mem_lane_align u_lane (
        .size      (curReq.size),
        .offset    (effOffset),
        .signExt   (curReq.signExt),
        .left      (curReq.left),
        .right     (curReq.right),
        .storeData (curReq.rt),
        .memData   (DataMem_In),
        .byteEn    (laneEn),
        .storeOut  (laneStore),
        .loadOut   (laneLoad)
    );

    assign result = (curReq.llsc & curReq.write) ? 32'd1 :
                    curReq.read                  ? laneLoad : 32'd0;

    assign DataMem_Address = issue ? curReq.addr[ADDR_WIDTH+1:2] : '0;
    assign DataMem_Read    = issue & curReq.read;
    assign DataMem_Write   = (issue & curReq.write) ? laneEn : BE_NONE;
    assign DataMem_Out     = (issue & curReq.write) ? laneStore : 32'd0;
    assign M_MemStall      = issue & ~DataMem_Ready;
    assign M_ReadData      = (state == ST_DONE)        ? dataLatch :
                             (completing & ~discard)   ? result    : 32'd0;
    assign M_Exc_AdEL      = ~reset & (state == ST_IDLE) & M_MemRead & ~aligned & ~M_Flush;
    assign M_Exc_AdES      = ~reset & (state == ST_IDLE) & M_MemWrite & ~aligned & ~M_Flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            heldReq   <= '0;
            llBit     <= 1'b0;
            llAddr    <= 30'd0;
            dataLatch <= 32'd0;
            flushed   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        if (DataMem_Ready) begin
                            dataLatch <= result;
                            if (M_Stall) begin
                                state <= ST_DONE;
                            end
                        end else begin
                            heldReq <= liveReq;
                            flushed <= 1'b0;
                            state   <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (M_Flush) begin
                        flushed <= 1'b1;
                    end
                    if (DataMem_Ready) begin
                        if (discard) begin
                            state <= ST_IDLE;
                        end else begin
                            dataLatch <= result;
                            state     <= M_Stall ? ST_DONE : ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (!M_Stall) begin
                        state <= ST_IDLE;
                    end
                end
            endcase

            // ERET has priority over both SC and an LL completing in the same cycle.
            if (M_Eret) begin
                llBit <= 1'b0;
            end else if ((state == ST_IDLE) & isSc & ~M_Flush) begin
                llBit <= 1'b0;
            end else if (completing & ~discard & curReq.llsc & curReq.read) begin
                llBit  <= 1'b1;
                llAddr <= curReq.addr[31:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
    logic        M_Left, M_Right, M_ReverseEndian, M_LLSC;
    logic [31:0] M_ALU_Result, M_ReadData2;
    logic        M_Flush, M_Stall, M_Eret;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic [29:0] DataMem_Address;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [31:0] DataMem_Out;
    logic        M_MemStall;
    logic [31:0] M_ReadData;
    logic        M_Exc_AdEL, M_Exc_AdES;

    int checks   = 0;
    int failures = 0;
    int stalls;

    typedef struct {
        string       name;
        logic [29:0] addr;
        logic        rd;
        logic [3:0]  we;
        logic [31:0] dout;
        logic [31:0] rdata;
    } exp_t;

    exp_t expQ[$];

    mem_access_ctrl #(.ADDR_WIDTH(30)) dut (
        .clock           (clock),
        .reset           (reset),
        .M_MemRead       (M_MemRead),
        .M_MemWrite      (M_MemWrite),
        .M_MemByte       (M_MemByte),
        .M_MemHalf       (M_MemHalf),
        .M_MemSignExtend (M_MemSignExtend),
        .M_Left          (M_Left),
        .M_Right         (M_Right),
        .M_ReverseEndian (M_ReverseEndian),
        .M_LLSC          (M_LLSC),
        .M_ALU_Result    (M_ALU_Result),
        .M_ReadData2     (M_ReadData2),
        .M_Flush         (M_Flush),
        .M_Stall         (M_Stall),
        .M_Eret          (M_Eret),
        .DataMem_In      (DataMem_In),
        .DataMem_Ready   (DataMem_Ready),
        .DataMem_Address (DataMem_Address),
        .DataMem_Read    (DataMem_Read),
        .DataMem_Write   (DataMem_Write),
        .DataMem_Out     (DataMem_Out),
        .M_MemStall      (M_MemStall),
        .M_ReadData      (M_ReadData),
        .M_Exc_AdEL      (M_Exc_AdEL),
        .M_Exc_AdES      (M_Exc_AdES)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushExp(input string name, input logic [29:0] addr, input logic rd,
                           input logic [3:0] we, input logic [31:0] dout, input logic [31:0] rdata);
        exp_t e;
        e.name = name; e.addr = addr; e.rd = rd; e.we = we; e.dout = dout; e.rdata = rdata;
        expQ.push_back(e);
    endtask

    task automatic clearInputs();
        M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0; M_MemSignExtend = 0;
        M_Left = 0; M_Right = 0; M_ReverseEndian = 0; M_LLSC = 0;
        M_ALU_Result = 0; M_ReadData2 = 0; M_Flush = 0; M_Stall = 0; M_Eret = 0;
        DataMem_In = 0;
    endtask

    // Drives the bus handshake for the access already on the inputs; Ready arrives after lat cycles.
    task automatic runBus(input int lat, input int flushAt, input int stallHold,
                          input logic [31:0] holdData, output int stallCount);
        stallCount = 0;
        for (int c = 0; c <= lat; c++) begin
            DataMem_Ready = (c == lat);
            M_Flush       = (c == flushAt);
            M_Stall       = (c == lat) && (stallHold > 0);
            @(negedge clock);
            if (M_MemStall) stallCount++;
            @(posedge clock); #1;
        end
        M_Flush = 0;
        for (int h = 0; h <= stallHold && stallHold > 0; h++) begin
            M_Stall       = (h < stallHold);
            DataMem_Ready = 1;
            @(negedge clock);
            check("done_no_reissue", {31'd0, DataMem_Read}, 32'd0);
            check("done_readdata", M_ReadData, holdData);
            @(posedge clock); #1;
        end
        DataMem_Ready = 0;
        clearInputs();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && DataMem_Ready && (DataMem_Read || DataMem_Write != 4'b0000)) begin
                if (expQ.size() == 0) begin
                    check("unexpected_txn", {2'b00, DataMem_Address}, 32'hFFFFFFFF);
                end else begin
                    e = expQ.pop_front();
                    check({e.name, "_addr"}, {2'b00, DataMem_Address}, {2'b00, e.addr});
                    check({e.name, "_rd"}, {31'd0, DataMem_Read}, {31'd0, e.rd});
                    check({e.name, "_we"}, {28'd0, DataMem_Write}, {28'd0, e.we});
                    check({e.name, "_dout"}, DataMem_Out, e.dout);
                    check({e.name, "_rdata"}, M_ReadData, e.rdata);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        reset = 1; DataMem_Ready = 0;
        clearInputs();
        @(negedge clock);
        check("rst_read", {31'd0, DataMem_Read}, 32'd0);
        check("rst_write", {28'd0, DataMem_Write}, 32'd0);
        check("rst_addr", {2'b00, DataMem_Address}, 32'd0);
        check("rst_stall", {31'd0, M_MemStall}, 32'd0);
        check("rst_rdata", M_ReadData, 32'd0);
        check("rst_exc", {30'd0, M_Exc_AdEL, M_Exc_AdES}, 32'd0);
        @(posedge clock); #1;
        reset = 0;

        // LB sign-extended, same-cycle ready
        M_MemRead = 1; M_MemByte = 1; M_MemSignExtend = 1; M_ALU_Result = 32'h201; DataMem_In = 32'h11823344;
        pushExp("lb_sext", 30'h80, 1, 4'b0000, 32'd0, 32'hFFFFFF82);
        runBus(0, -1, 0, 0, stalls);
        check("lb_stall", stalls, 0);

        // LB little-endian: offset 1 maps to bits 15:8
        M_MemRead = 1; M_MemByte = 1; M_MemSignExtend = 1; M_ReverseEndian = 1;
        M_ALU_Result = 32'h201; DataMem_In = 32'h11823344;
        pushExp("lb_rev", 30'h80, 1, 4'b0000, 32'd0, 32'h00000033);
        runBus(0, -1, 0, 0, stalls);

        // SB little-endian at offset 0 hits lane 0
        M_MemWrite = 1; M_MemByte = 1; M_ReverseEndian = 1; M_ALU_Result = 32'h200; M_ReadData2 = 32'h000000A5;
        pushExp("sb_rev", 30'h80, 0, 4'b0001, 32'hA5A5A5A5, 32'd0);
        runBus(1, -1, 0, 0, stalls);
        check("sb_stall", stalls, 1);

        // SH at offset 2, ready after 3 cycles
        M_MemWrite = 1; M_MemHalf = 1; M_ALU_Result = 32'h202; M_ReadData2 = 32'h0000BEEF;
        pushExp("sh", 30'h80, 0, 4'b0011, 32'hBEEFBEEF, 32'd0);
        runBus(3, -1, 0, 0, stalls);
        check("sh_stall", stalls, 3);

        // Misaligned word load and store
        M_MemRead = 1; M_ALU_Result = 32'h202;
        @(negedge clock);
        check("lw_adel", {31'd0, M_Exc_AdEL}, 32'd1);
        check("lw_adel_noread", {31'd0, DataMem_Read}, 32'd0);
        check("lw_adel_nostall", {31'd0, M_MemStall}, 32'd0);
        @(posedge clock); #1;
        clearInputs();
        M_MemWrite = 1; M_ALU_Result = 32'h201; M_ReadData2 = 32'h12345678;
        @(negedge clock);
        check("sw_ades", {31'd0, M_Exc_AdES}, 32'd1);
        check("sw_ades_nowrite", {28'd0, DataMem_Write}, 32'd0);
        @(posedge clock); #1;
        clearInputs();

        // LWL offset 1, SWR offset 2
        M_MemRead = 1; M_Left = 1; M_ALU_Result = 32'h301; M_ReadData2 = 32'h11223344; DataMem_In = 32'hAABBCCDD;
        pushExp("lwl", 30'hC0, 1, 4'b0000, 32'd0, 32'hBBCCDD44);
        runBus(2, -1, 0, 0, stalls);
        M_MemWrite = 1; M_Right = 1; M_ALU_Result = 32'h302; M_ReadData2 = 32'h11223344;
        pushExp("swr", 30'hC0, 0, 4'b1110, 32'h22334400, 32'd0);
        runBus(0, -1, 0, 0, stalls);

        // LL then SC succeeds
        M_MemRead = 1; M_LLSC = 1; M_ALU_Result = 32'h100; DataMem_In = 32'h12345678;
        pushExp("ll", 30'h40, 1, 4'b0000, 32'd0, 32'h12345678);
        runBus(0, -1, 0, 0, stalls);
        M_MemWrite = 1; M_LLSC = 1; M_ALU_Result = 32'h100; M_ReadData2 = 32'hCAFEF00D;
        pushExp("sc_ok", 30'h40, 0, 4'b1111, 32'hCAFEF00D, 32'd1);
        runBus(0, -1, 0, 0, stalls);

        // Second SC fails with no bus access
        M_MemWrite = 1; M_LLSC = 1; M_ALU_Result = 32'h100; M_ReadData2 = 32'hCAFEF00D; DataMem_Ready = 1;
        @(negedge clock);
        check("sc2_nowrite", {28'd0, DataMem_Write}, 32'd0);
        check("sc2_rdata", M_ReadData, 32'd0);
        check("sc2_nostall", {31'd0, M_MemStall}, 32'd0);
        @(posedge clock); #1;
        DataMem_Ready = 0;
        clearInputs();

        // LL then SC to a different word fails
        M_MemRead = 1; M_LLSC = 1; M_ALU_Result = 32'h100; DataMem_In = 32'h0000BEEF;
        pushExp("ll2", 30'h40, 1, 4'b0000, 32'd0, 32'h0000BEEF);
        runBus(0, -1, 0, 0, stalls);
        M_MemWrite = 1; M_LLSC = 1; M_ALU_Result = 32'h104; DataMem_Ready = 1;
        @(negedge clock);
        check("sc_addr_nowrite", {28'd0, DataMem_Write}, 32'd0);
        @(posedge clock); #1;
        DataMem_Ready = 0;
        clearInputs();

        // LL, ERET, SC fails
        M_MemRead = 1; M_LLSC = 1; M_ALU_Result = 32'h100; DataMem_In = 32'h00000077;
        pushExp("ll3", 30'h40, 1, 4'b0000, 32'd0, 32'h00000077);
        runBus(0, -1, 0, 0, stalls);
        M_Eret = 1;
        @(posedge clock); #1;
        clearInputs();
        M_MemWrite = 1; M_LLSC = 1; M_ALU_Result = 32'h100; DataMem_Ready = 1;
        @(negedge clock);
        check("sc_eret_nowrite", {28'd0, DataMem_Write}, 32'd0);
        check("sc_eret_rdata", M_ReadData, 32'd0);
        @(posedge clock); #1;
        DataMem_Ready = 0;
        clearInputs();

        // External stall held 4 cycles after Ready: one request, data held
        M_MemRead = 1; M_ALU_Result = 32'h400; DataMem_In = 32'h0BADF00D;
        pushExp("lw_stall", 30'h100, 1, 4'b0000, 32'd0, 32'h0BADF00D);
        runBus(1, -1, 4, 32'h0BADF00D, stalls);
        check("lw_stall_cycles", stalls, 1);

        // Flush during ACCESS: bus completes, data dropped
        M_MemRead = 1; M_ALU_Result = 32'h500; DataMem_In = 32'h55AA55AA;
        pushExp("lw_flush", 30'h140, 1, 4'b0000, 32'd0, 32'd0);
        runBus(3, 1, 0, 0, stalls);
        check("flush_stall_cycles", stalls, 3);
        @(negedge clock);
        check("flush_idle_read", {31'd0, DataMem_Read}, 32'd0);
        check("flush_idle_stall", {31'd0, M_MemStall}, 32'd0);
        @(posedge clock); #1;

        // Reset in the middle of ACCESS
        M_MemRead = 1; M_ALU_Result = 32'h600;
        @(posedge clock); #2;
        reset = 1;
        @(negedge clock);
        check("rst_mid_read", {31'd0, DataMem_Read}, 32'd0);
        check("rst_mid_stall", {31'd0, M_MemStall}, 32'd0);
        @(posedge clock); #1;
        clearInputs();
        reset = 0;
        @(negedge clock);
        check("post_rst_read", {31'd0, DataMem_Read}, 32'd0);
        @(posedge clock); #1;

        M_MemRead = 1; M_ALU_Result = 32'h10; DataMem_In = 32'h600D600D;
        pushExp("lw_recover", 30'h4, 1, 4'b0000, 32'd0, 32'h600D600D);
        runBus(0, -1, 0, 0, stalls);

        repeat (2) @(posedge clock);
        check("queue_drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
